// File: rtl/hesap_denetleyici.sv
// Sequencing controller for the calculator datapath: dispatches one request to one of seven
// operation units, waits for its done flag (with timeout) and returns the captured result.
module hesap_denetleyici #(
  parameter int ZAMAN_ASIMI = 64,
  parameter int SAYAC_GEN   = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         baslat,
  input  logic [31:0]  sayi1,
  input  logic [31:0]  sayi2,
  input  logic [2:0]   tur,
  output logic [31:0]  birim_sayi1,
  output logic [31:0]  birim_sayi2,
  output logic [6:0]   birim_baslat,
  input  logic [6:0]   birim_hazir,
  input  logic [6:0]   birim_gecerli,
  input  logic [6:0]   birim_tasma,
  input  logic [447:0] birim_sonuc,
  output logic         mesgul,
  output logic [63:0]  sonuc,
  output logic         hazir,
  output logic         gecerli,
  output logic         tasma,
  output logic         zaman_asimi
);

  typedef enum logic [1:0] {BOS, YUKLE, BEKLE, BITTI} durum_t;

  localparam logic [SAYAC_GEN-1:0] SON_SAYAC = SAYAC_GEN'(ZAMAN_ASIMI - 1);

  durum_t               durum, durum_d;
  logic [2:0]           tur_q, tur_d;
  logic [SAYAC_GEN-1:0] sayac, sayac_d;
  logic [31:0]          birim_sayi1_d, birim_sayi2_d;
  logic [6:0]           birim_baslat_d;
  logic [63:0]          sonuc_d;
  logic                 mesgul_d, hazir_d, gecerli_d, tasma_d, zaman_asimi_d;

  logic                 sec_hazir, sec_gecerli, sec_tasma;
  logic [63:0]          sec_sonuc;

  // Only the dispatched unit's flags are ever looked at.
  always_comb begin
    sec_hazir   = 1'b0;
    sec_gecerli = 1'b0;
    sec_tasma   = 1'b0;
    sec_sonuc   = '0;
    for (int k = 0; k < 7; k++) begin
      if (tur_q == 3'(k)) begin
        sec_hazir   = birim_hazir[k];
        sec_gecerli = birim_gecerli[k];
        sec_tasma   = birim_tasma[k];
        sec_sonuc   = birim_sonuc[64*k +: 64];
      end
    end
  end

  always_comb begin
    durum_d        = durum;
    tur_d          = tur_q;
    sayac_d        = sayac;
    birim_sayi1_d  = birim_sayi1;
    birim_sayi2_d  = birim_sayi2;
    birim_baslat_d = '0;
    sonuc_d        = sonuc;
    mesgul_d       = mesgul;
    hazir_d        = 1'b0;
    gecerli_d      = gecerli;
    tasma_d        = tasma;
    zaman_asimi_d  = zaman_asimi;

    case (durum)
      BOS: begin
        if (baslat) begin
          mesgul_d      = 1'b1;
          sonuc_d       = sonuc;
          gecerli_d     = 1'b0;
          tasma_d       = 1'b0;
          zaman_asimi_d = 1'b0;
          if (tur != 3'b111) begin
            tur_d         = tur;
            birim_sayi1_d = sayi1;
            birim_sayi2_d = sayi2;
            for (int k = 0; k < 7; k++) birim_baslat_d[k] = (tur == 3'(k));
            durum_d       = YUKLE;
          end else begin
            sonuc_d = '0;
            hazir_d = 1'b1;
            durum_d = BITTI;
          end
        end
      end
      YUKLE: begin
        sayac_d = '0;
        durum_d = BEKLE;
      end
      BEKLE: begin
        // A done flag on the last allowed cycle still beats the timeout.
        if (sec_hazir) begin
          sonuc_d   = sec_sonuc;
          gecerli_d = sec_gecerli;
          tasma_d   = sec_tasma;
          hazir_d   = 1'b1;
          durum_d   = BITTI;
        end else if (sayac == SON_SAYAC) begin
          sonuc_d       = '0;
          gecerli_d     = 1'b0;
          tasma_d       = 1'b0;
          zaman_asimi_d = 1'b1;
          hazir_d       = 1'b1;
          durum_d       = BITTI;
        end else begin
          sayac_d = sayac + 1'b1;
        end
      end
      BITTI: begin
        mesgul_d = 1'b0;
        durum_d  = BOS;
      end
      default: durum_d = BOS;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      durum        <= BOS;
      tur_q        <= '0;
      sayac        <= '0;
      birim_sayi1  <= '0;
      birim_sayi2  <= '0;
      birim_baslat <= '0;
      sonuc        <= '0;
      mesgul       <= 1'b0;
      hazir        <= 1'b0;
      gecerli      <= 1'b0;
      tasma        <= 1'b0;
      zaman_asimi  <= 1'b0;
    end else begin
      durum        <= durum_d;
      tur_q        <= tur_d;
      sayac        <= sayac_d;
      birim_sayi1  <= birim_sayi1_d;
      birim_sayi2  <= birim_sayi2_d;
      birim_baslat <= birim_baslat_d;
      sonuc        <= sonuc_d;
      mesgul       <= mesgul_d;
      hazir        <= hazir_d;
      gecerli      <= gecerli_d;
      tasma        <= tasma_d;
      zaman_asimi  <= zaman_asimi_d;
    end
  end

endmodule

// File: tb/tb_hesap_denetleyici.sv
// Bench for hesap_denetleyici: table vectors, reset sequences and random operations
// checked against a latency/result model of the controller.
module tb_hesap_denetleyici;

  localparam int ZA = 16;

  logic         clk = 1'b0;
  logic         rst, baslat;
  logic [31:0]  sayi1, sayi2;
  logic [2:0]   tur;
  logic [31:0]  birim_sayi1, birim_sayi2;
  logic [6:0]   birim_baslat, birim_hazir, birim_gecerli, birim_tasma;
  logic [447:0] birim_sonuc;
  logic         mesgul, hazir, gecerli, tasma, zaman_asimi;
  logic [63:0]  sonuc;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hesap_denetleyici #(.ZAMAN_ASIMI(ZA), .SAYAC_GEN(8)) dut (
    .clk(clk), .rst(rst), .baslat(baslat), .sayi1(sayi1), .sayi2(sayi2), .tur(tur),
    .birim_sayi1(birim_sayi1), .birim_sayi2(birim_sayi2), .birim_baslat(birim_baslat),
    .birim_hazir(birim_hazir), .birim_gecerli(birim_gecerli), .birim_tasma(birim_tasma),
    .birim_sonuc(birim_sonuc), .mesgul(mesgul), .sonuc(sonuc), .hazir(hazir),
    .gecerli(gecerli), .tasma(tasma), .zaman_asimi(zaman_asimi)
  );

  // d = cycles after the start pulse at which the unit raises hazir (-1: never, 0: stale only)
  typedef struct {
    logic [2:0]  t;
    logic [31:0] a;
    logic [31:0] b;
    int          d;
    logic [63:0] r;
    logic        g;
    logic        ts;
    int          exp_lat;
    logic [63:0] exp_son;
    logic        exp_gec;
    logic        exp_tas;
    logic        exp_za;
    bit          busy;
    bit          noise;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string ad, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", ad, act, exp);
    end
  endtask

  function automatic bit model_answers(input logic [2:0] t, input int d);
    return (t != 3'b111) && (d >= 1) && (d <= ZA);
  endfunction

  function automatic int model_lat(input logic [2:0] t, input int d);
    if (t == 3'b111) return 1;
    if (model_answers(t, d)) return d + 2;
    return ZA + 2;
  endfunction

  task automatic drive_units(input vec_t v, input int i);
    birim_hazir   = v.noise ? (7'($urandom) & ~(7'd1 << v.t)) : 7'd0;
    birim_gecerli = 7'($urandom);
    birim_tasma   = 7'($urandom);
    for (int k = 0; k < 14; k++) birim_sonuc[32*k +: 32] = $urandom;
    if (v.t != 3'b111 && i == v.d + 1) begin
      birim_hazir[v.t]            = 1'b1;
      birim_sonuc[64*v.t +: 64]   = v.r;
      birim_gecerli[v.t]          = v.g;
      birim_tasma[v.t]            = v.ts;
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the first idle cycle after hazir.
  task automatic run_op(input vec_t v, input string ad);
    int          hz_cyc = 0, n_hz = 0, n_puls = 0, puls_cyc = 0, mes_err = 0;
    logic [6:0]  puls_val = '0;
    logic [63:0] cap_son = '0;
    logic        cap_g = 1'b0, cap_t = 1'b0, cap_z = 1'b0;
    logic [31:0] bs1 = '0, bs2 = '0;
    logic [6:0]  onehot;
    onehot = (v.t == 3'b111) ? 7'd0 : (7'd1 << v.t);
    baslat = 1'b1; tur = v.t; sayi1 = v.a; sayi2 = v.b;
    for (int i = 1; i <= v.exp_lat + 1; i++) begin
      @(negedge clk);
      if (hazir) begin
        n_hz++;
        if (hz_cyc == 0) hz_cyc = i;
        cap_son = sonuc; cap_g = gecerli; cap_t = tasma; cap_z = zaman_asimi;
      end
      if (birim_baslat != 7'd0) begin
        n_puls++; puls_val = birim_baslat; puls_cyc = i;
      end
      if (mesgul !== (i <= v.exp_lat)) mes_err++;
      if (i == 2) begin bs1 = birim_sayi1; bs2 = birim_sayi2; end
      baslat = 1'b0;
      if (v.busy && i == 2) begin
        baslat = 1'b1; tur = 3'($urandom); sayi1 = $urandom; sayi2 = $urandom;
      end
      drive_units(v, i);
    end
    chk({ad, " hazir_cycle"}, 64'(hz_cyc), 64'(v.exp_lat));
    chk({ad, " hazir_count"}, 64'(n_hz), 64'd1);
    chk({ad, " pulse_count"}, 64'(n_puls), (v.t == 3'b111) ? 64'd0 : 64'd1);
    chk({ad, " pulse_onehot"}, 64'(puls_val), 64'(onehot));
    if (v.t != 3'b111) begin
      chk({ad, " pulse_cycle"}, 64'(puls_cyc), 64'd1);
      chk({ad, " operands"}, {bs1, bs2}, {v.a, v.b});
      chk({ad, " operands_held"}, {birim_sayi1, birim_sayi2}, {v.a, v.b});
    end
    chk({ad, " mesgul_errors"}, 64'(mes_err), 64'd0);
    chk({ad, " sonuc"}, cap_son, v.exp_son);
    chk({ad, " flags"}, {61'd0, cap_g, cap_t, cap_z}, {61'd0, v.exp_gec, v.exp_tas, v.exp_za});
    chk({ad, " held"}, {sonuc[62:0], gecerli}, {v.exp_son[62:0], v.exp_gec});
    chk({ad, " held_flags"}, {62'd0, tasma, zaman_asimi}, {62'd0, v.exp_tas, v.exp_za});
  endtask

  initial begin
    vec_t v;
    int   act;
    tbl[0] = '{3'd0, 32'd5, 32'd7, 3, 64'd12, 1'b1, 1'b0, 5, 64'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{3'd7, 32'd1, 32'd2, -1, 64'd99, 1'b1, 1'b1, 1, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{3'd3, 32'd9, 32'd3, -1, 64'd3, 1'b1, 1'b0, 18, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{3'd2, 32'd6, 32'd8, 4, 64'h30, 1'b1, 1'b0, 6, 64'h30, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[4] = '{3'd4, 32'd4, 32'd0, 16, 64'hFFFF_FFFF_0000_0001, 1'b1, 1'b1, 18,
               64'hFFFF_FFFF_0000_0001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{3'd5, 32'h100, 32'd0, 1, 64'hABCD, 1'b0, 1'b0, 3, 64'hABCD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{3'd6, 32'h200, 32'd0, 0, 64'h55, 1'b1, 1'b1, 18, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{3'd1, 32'd20, 32'd3, 17, 64'h11, 1'b1, 1'b0, 18, 64'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[8] = '{3'd0, 32'd2, 32'd2, 2, 64'h8000_0000_0000_0004, 1'b0, 1'b1, 4,
               64'h8000_0000_0000_0004, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    rst = 1'b1; baslat = 1'b0; sayi1 = '0; sayi2 = '0; tur = '0;
    birim_hazir = '0; birim_gecerli = '0; birim_tasma = '0; birim_sonuc = '0;
    repeat (2) @(negedge clk);
    chk("reset sonuc", sonuc, 64'd0);
    chk("reset operands", {birim_sayi1, birim_sayi2}, 64'd0);
    chk("reset control", {57'd0, birim_baslat}, 64'd0);
    chk("reset flags", {59'd0, hazir, gecerli, tasma, zaman_asimi, mesgul}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int n = 0; n < 9; n++) run_op(tbl[n], $sformatf("vec%0d", n));

    // Reset while waiting on a unit: everything clears and no completion follows.
    birim_hazir = '0;
    baslat = 1'b1; tur = 3'd2; sayi1 = 32'hDEAD; sayi2 = 32'hBEEF;
    @(negedge clk);
    baslat = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst sonuc", sonuc, 64'd0);
    chk("midrst operands", {birim_sayi1, birim_sayi2}, 64'd0);
    chk("midrst outputs", {52'd0, birim_baslat, hazir, gecerli, tasma, zaman_asimi, mesgul}, 64'd0);
    act = 0;
    repeat (ZA + 4) begin
      @(negedge clk);
      if (hazir || mesgul || birim_baslat != 7'd0) act++;
    end
    chk("midrst quiet", 64'(act), 64'd0);
    run_op(tbl[0], "after_rst");

    for (int n = 0; n < 40; n++) begin
      v.t = 3'($urandom_range(0, 7));
      v.a = $urandom; v.b = $urandom;
      case ($urandom_range(0, 3))
        0:       v.d = -1;
        1:       v.d = $urandom_range(0, 2);
        default: v.d = $urandom_range(1, ZA + 2);
      endcase
      v.r = {$urandom, $urandom};
      v.g = 1'($urandom); v.ts = 1'($urandom);
      v.busy  = (v.t != 3'b111) && ($urandom_range(0, 1) == 1);
      v.noise = ($urandom_range(0, 1) == 1);
      v.exp_lat = model_lat(v.t, v.d);
      v.exp_son = model_answers(v.t, v.d) ? v.r : 64'd0;
      v.exp_gec = model_answers(v.t, v.d) ? v.g : 1'b0;
      v.exp_tas = model_answers(v.t, v.d) ? v.ts : 1'b0;
      v.exp_za  = (v.t != 3'b111) && !model_answers(v.t, v.d);
      run_op(v, $sformatf("rnd%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
